adder63_arbiter: RTL and testbench

//  Shares one unsigned 63-bit adder (Sum = A + {1'b0,B}, 64-bit result) between two requesters.

---
 rtl/adder63_arbiter_if.sv | 34 +++
 rtl/adder63_arbiter.sv | 82 ++++++++
 tb/tb_adder63_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder63_arbiter_if.sv
// Request/response bundle for the shared 63-bit adder: two valid/ready request ports
// and one registered, id-tagged response port.
interface adder63_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [62:0] req0_a;
  logic [61:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [62:0] req1_a;
  logic [61:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_sum;
  logic        rsp_id;

  // Requesters plus response consumer.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_id
  );

  // The arbitrated adder.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/adder63_arbiter.sv
// One unsigned 63-bit adder shared by two valid/ready requesters, round-robin or
// fixed-priority arbitration, one-deep registered response with requester id.
module adder63_arbiter #(
  parameter bit          FAIR_RR = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder63_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]     op_count
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_sum_q, rsp_sum_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic [63:0]      sum0, sum1;

  // B is one bit narrower than A, so the 64-bit result can never overflow.
  assign sum0 = {1'b0, bus.req0_a} + {2'b00, bus.req0_b};
  assign sum1 = {1'b0, bus.req1_a} + {2'b00, bus.req1_b};

  always_comb begin
    can_accept = ~rsp_valid_q | bus.rsp_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      // Tie: round-robin hands it to the port that did not win last.
      grant0 = FAIR_RR ? last_grant_q : 1'b1;
      grant1 = ~grant0;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
    accept = can_accept & (grant0 | grant1);

    rsp_valid_d  = rsp_valid_q & ~bus.rsp_ready;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_sum_d    = grant1 ? sum1 : sum0;
      last_grant_d = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      op_count_q   <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req0_ready = can_accept & grant0 & rst_n;
  assign bus.req1_ready = can_accept & grant1 & rst_n;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_id     = rsp_id_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_adder63_arbiter.sv
// Scoreboard bench: a round-robin instance (4-bit counter) checked every cycle against a
// reference model, plus a fixed-priority instance checked during the tie burst.
module tb_adder63_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0v, r1v, rsp_rdy;
  logic [62:0] r0a, r1a;
  logic [61:0] r0b, r1b;
  logic [3:0]  cnt_rr;
  logic [15:0] cnt_fp;

  adder63_arbiter_if if_rr ();
  adder63_arbiter_if if_fp ();

  assign if_rr.req0_valid = r0v;
  assign if_rr.req0_a     = r0a;
  assign if_rr.req0_b     = r0b;
  assign if_rr.req1_valid = r1v;
  assign if_rr.req1_a     = r1a;
  assign if_rr.req1_b     = r1b;
  assign if_rr.rsp_ready  = rsp_rdy;
  assign if_fp.req0_valid = r0v;
  assign if_fp.req0_a     = r0a;
  assign if_fp.req0_b     = r0b;
  assign if_fp.req1_valid = r1v;
  assign if_fp.req1_a     = r1a;
  assign if_fp.req1_b     = r1b;
  assign if_fp.rsp_ready  = rsp_rdy;

  adder63_arbiter #(.FAIR_RR(1'b1), .CNT_W(4)) u_dut_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if_rr.slave),
    .op_count (cnt_rr)
  );

  adder63_arbiter #(.FAIR_RR(1'b0), .CNT_W(16)) u_dut_fp (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if_fp.slave),
    .op_count (cnt_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [63:0] sum;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_last;
  logic [3:0] m_cnt;
  logic [63:0] m_sum;
  logic       acc0, acc1;
  logic       rec_en, fp_en;
  logic       seq_q[$];

  // Reference model and scoreboard, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    logic exp_vld, can, g0, g1;
    exp_t e;
    if (!rst_n) begin
      chk("rst_req0_ready", {63'd0, if_rr.req0_ready}, 64'd0);
      chk("rst_req1_ready", {63'd0, if_rr.req1_ready}, 64'd0);
      exp_q.delete();
      m_cnt  = '0;
      m_last = 1'b1;
      m_sum  = '0;
      acc0   = 1'b0;
      acc1   = 1'b0;
    end else begin
      exp_vld = (exp_q.size() != 0);
      chk("rsp_valid", {63'd0, if_rr.rsp_valid}, {63'd0, exp_vld});
      chk("op_count", {60'd0, cnt_rr}, {60'd0, m_cnt});
      can = !exp_vld || rsp_rdy;
      g0  = r0v && (!r1v || m_last);
      g1  = r1v && !g0;
      chk("req0_ready", {63'd0, if_rr.req0_ready}, {63'd0, can && g0});
      chk("req1_ready", {63'd0, if_rr.req1_ready}, {63'd0, can && g1});
      if (exp_vld) begin
        chk("rsp_sum", if_rr.rsp_sum, exp_q[0].sum);
        chk("rsp_id", {63'd0, if_rr.rsp_id}, {63'd0, exp_q[0].id});
        if (rsp_rdy) begin
          e = exp_q.pop_front();
          m_sum = e.sum;
          m_cnt = m_cnt + 4'd1;
          if (rec_en) seq_q.push_back(if_rr.rsp_id);
        end
      end else begin
        chk("rsp_sum_hold", if_rr.rsp_sum, m_sum);
      end
      acc0 = can && g0;
      acc1 = can && g1;
      if (acc0) begin
        e.id  = 1'b0;
        e.sum = {1'b0, r0a} + {2'b00, r0b};
        exp_q.push_back(e);
        m_last = 1'b0;
      end else if (acc1) begin
        e.id  = 1'b1;
        e.sum = {1'b0, r1a} + {2'b00, r1b};
        exp_q.push_back(e);
        m_last = 1'b1;
      end
      if (fp_en) begin
        chk("fp_req0_ready", {63'd0, if_fp.req0_ready}, 64'd1);
        chk("fp_req1_ready", {63'd0, if_fp.req1_ready}, 64'd0);
        if (if_fp.rsp_valid) chk("fp_rsp_id", {63'd0, if_fp.rsp_id}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b1;
    r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    rec_en = 1'b0; fp_en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single request on each port, including the widest possible sum.
    r0v = 1'b1; r0a = 63'd1; r0b = 62'd2;
    step();
    r0v = 1'b0;
    step();
    chk("t1_sum", if_rr.rsp_sum, 64'd3);
    r1v = 1'b1; r1a = 63'h7FFF_FFFF_FFFF_FFFF; r1b = 62'h3FFF_FFFF_FFFF_FFFF;
    step();
    r1v = 1'b0;
    step();
    chk("t2_sum", if_rr.rsp_sum, 64'hBFFF_FFFF_FFFF_FFFE);
    step();

    // Six-cycle tie: alternation on the RR instance, req0 only on the fixed one.
    rec_en = 1'b1; fp_en = 1'b1;
    r0v = 1'b1; r0a = 63'd10; r0b = 62'd1;
    r1v = 1'b1; r1a = 63'd20; r1b = 62'd2;
    repeat (6) step();
    fp_en = 1'b0; r0v = 1'b0; r1v = 1'b0;
    repeat (2) step();
    rec_en = 1'b0;
    chk("t3_seq_len", 64'(seq_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < seq_q.size(); i++) begin
      chk("t3_seq_id", {63'd0, seq_q[i]}, 64'(i % 2));
    end

    // Back-pressure for three cycles, then drain and accept in the same cycle.
    rsp_rdy = 1'b0;
    r0v = 1'b1; r0a = 63'd5; r0b = 62'd6;
    step();
    r0v = 1'b0; r1v = 1'b1; r1a = 63'd7; r1b = 62'd8;
    repeat (3) step();
    rsp_rdy = 1'b1;
    step();
    r1v = 1'b0;
    chk("t4_no_bubble", {63'd0, if_rr.rsp_valid}, 64'd1);
    chk("t4_next_sum", if_rr.rsp_sum, 64'd15);
    repeat (2) step();

    // Reset while a result is pending; the first tie afterwards goes to req0.
    rsp_rdy = 1'b0;
    r0v = 1'b1; r0a = 63'd1; r0b = 62'd1;
    step();
    r0v = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_rsp_valid", {63'd0, if_rr.rsp_valid}, 64'd0);
    chk("t5_op_count", {60'd0, cnt_rr}, 64'd0);
    rsp_rdy = 1'b1; r0v = 1'b1; r1v = 1'b1;
    step();
    r0v = 1'b0; r1v = 1'b0;
    chk("t5_tie_id", {63'd0, if_rr.rsp_id}, 64'd0);
    repeat (2) step();

    // Counter wrap with a 4-bit counter.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    r0v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r0a = 63'({$urandom(), $urandom()});
      r0b = 62'({$urandom(), $urandom()});
      step();
    end
    r0v = 1'b0;
    repeat (2) step();
    chk("t6_wrap16", {60'd0, cnt_rr}, 64'd0);
    r0v = 1'b1;
    step();
    r0v = 1'b0;
    repeat (2) step();
    chk("t6_count17", {60'd0, cnt_rr}, 64'd1);

    // Random traffic; a valid request holds its operands until accepted.
    for (int i = 0; i < 300; i++) begin
      if (!r0v || acc0) begin
        r0v = 1'($urandom_range(0, 1));
        r0a = 63'({$urandom(), $urandom()});
        r0b = 62'({$urandom(), $urandom()});
      end
      if (!r1v || acc1) begin
        r1v = 1'($urandom_range(0, 1));
        r1a = 63'({$urandom(), $urandom()});
        r1b = 62'({$urandom(), $urandom()});
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b1;
    repeat (3) step();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
